// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared match-sequencer types, winner codes and defaults
package game_pkg;

  typedef enum logic [2:0] {
    WAIT_BALL,
    DELIVER,
    SETTLE,
    CHECK,
    INN_BREAK,
    MATCH_OVER
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_T1   = 2'b01;
  localparam logic [1:0] WIN_T2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  localparam int MAX_WICKETS_DEF = 10;

  // Falling one run short of the target is a tie; anything less is a team 1 win.
  function automatic logic [1:0] decide_winner(input logic [8:0] runs,
                                               input logic [8:0] tgt);
    if (runs >= tgt)
      return WIN_T2;
    else if (runs == tgt - 9'd1)
      return WIN_TIE;
    else
      return WIN_T1;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - two-flop synchronizer with a one-cycle rising-edge pulse
module btn_sync_edge (
  input  logic clk_fpga,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign press = sync2 & ~sync2_d;

endmodule

// File: rtl/innings_controller.sv
// rtl/innings_controller.sv - ball/over sequencer, innings switch, chase target and result
module innings_controller
  import game_pkg::*;
#(
  parameter int BALLS_PER_OVER    = 6,
  parameter int OVERS_PER_INNINGS = 2,
  parameter int MAX_WICKETS       = MAX_WICKETS_DEF,
  parameter int SETTLE_CYCLES     = 2
) (
  input  logic       clk_fpga,
  input  logic       reset,
  input  logic       bowl_btn,
  input  logic [7:0] binaryRuns,
  input  logic [3:0] binaryWickets,
  output logic       delivery,
  output logic       teamSwitch,
  output logic       gameOver,
  output logic [2:0] ballInOver,
  output logic [3:0] overCount,
  output logic [8:0] target,
  output logic [1:0] winner
);

  state_t     state;
  logic       innings2;
  logic [7:0] settle_cnt;
  logic       press;

  logic       over_done;
  logic [2:0] ball_next;
  logic [3:0] over_next;
  logic       end_inn;

  btn_sync_edge u_bowl_sync (
    .clk_fpga (clk_fpga),
    .reset    (reset),
    .btn      (bowl_btn),
    .press    (press)
  );

  // Wicket, over and chase conditions are folded into one decision so the innings ends once.
  always_comb begin
    over_done = (ballInOver == 3'(BALLS_PER_OVER - 1));
    ball_next = over_done ? 3'd0 : ballInOver + 3'd1;
    over_next = over_done ? overCount + 4'd1 : overCount;
    end_inn   = (binaryWickets >= 4'(MAX_WICKETS)) ||
                (over_next == 4'(OVERS_PER_INNINGS)) ||
                (innings2 && ({1'b0, binaryRuns} >= target));
  end

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      state      <= WAIT_BALL;
      innings2   <= 1'b0;
      settle_cnt <= 8'd0;
      delivery   <= 1'b0;
      teamSwitch <= 1'b0;
      gameOver   <= 1'b0;
      ballInOver <= 3'd0;
      overCount  <= 4'd0;
      target     <= 9'd0;
      winner     <= WIN_NONE;
    end else begin
      delivery <= 1'b0;
      case (state)
        WAIT_BALL: begin
          if (press) begin
            delivery <= 1'b1;
            state    <= DELIVER;
          end
        end
        DELIVER: begin
          settle_cnt <= 8'(SETTLE_CYCLES - 1);
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == 8'd0)
            state <= CHECK;
          else
            settle_cnt <= settle_cnt - 8'd1;
        end
        CHECK: begin
          ballInOver <= ball_next;
          overCount  <= over_next;
          if (!end_inn) begin
            state <= WAIT_BALL;
          end else if (!innings2) begin
            target <= {1'b0, binaryRuns} + 9'd1;
            state  <= INN_BREAK;
          end else begin
            winner   <= decide_winner({1'b0, binaryRuns}, target);
            gameOver <= 1'b1;
            state    <= MATCH_OVER;
          end
        end
        INN_BREAK: begin
          // The press that starts innings 2 is consumed here and bowls nothing.
          if (press) begin
            teamSwitch <= 1'b1;
            innings2   <= 1'b1;
            ballInOver <= 3'd0;
            overCount  <= 4'd0;
            state      <= WAIT_BALL;
          end
        end
        MATCH_OVER: begin
        end
        default: state <= WAIT_BALL;
      endcase
    end
  end

endmodule

// File: tb/tb_innings_controller.sv
// tb/tb_innings_controller.sv - directed bench for innings_controller with a match-level model
module tb_innings_controller;

  localparam int BPO   = 6;
  localparam int OVERS = 2;
  localparam int MAXW  = 10;
  localparam int S     = 2;

  logic       clk_fpga = 1'b0;
  logic       reset    = 1'b1;
  logic       bowl_btn = 1'b0;
  logic [7:0] binaryRuns = 8'd0;
  logic [3:0] binaryWickets = 4'd0;
  logic       delivery;
  logic       teamSwitch;
  logic       gameOver;
  logic [2:0] ballInOver;
  logic [3:0] overCount;
  logic [8:0] target;
  logic [1:0] winner;

  innings_controller #(
    .BALLS_PER_OVER    (BPO),
    .OVERS_PER_INNINGS (OVERS),
    .MAX_WICKETS       (MAXW),
    .SETTLE_CYCLES     (S)
  ) dut (
    .clk_fpga      (clk_fpga),
    .reset         (reset),
    .bowl_btn      (bowl_btn),
    .binaryRuns    (binaryRuns),
    .binaryWickets (binaryWickets),
    .delivery      (delivery),
    .teamSwitch    (teamSwitch),
    .gameOver      (gameOver),
    .ballInOver    (ballInOver),
    .overCount     (overCount),
    .target        (target),
    .winner        (winner)
  );

  always #5 clk_fpga = ~clk_fpga;

  int vectors    = 0;
  int miscompares = 0;
  int n_del      = 0;
  bit armed      = 1'b0;

  // Match-level model: balls counted as one running total per innings.
  localparam int M_IDLE = 0, M_BUSY = 1, M_BRK = 2, M_OVER = 3;
  int m_mode   = M_IDLE;
  int m_cnt    = 0;
  int m_balls  = 0;
  int m_target = 0;
  int m_winner = 0;
  bit m_inn2   = 1'b0;
  bit m_go     = 1'b0;
  bit m_ts     = 1'b0;
  bit m_del    = 1'b0;
  bit h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

  always @(posedge clk_fpga) begin
    if (reset) begin
      h1 <= 1'b0; h2 <= 1'b0; h3 <= 1'b0;
      m_mode <= M_IDLE; m_cnt <= 0; m_balls <= 0; m_target <= 0;
      m_winner <= 0; m_inn2 <= 1'b0; m_go <= 1'b0; m_ts <= 1'b0; m_del <= 1'b0;
    end else begin
      h1 <= bowl_btn; h2 <= h1; h3 <= h2;
      m_del <= 1'b0;
      case (m_mode)
        M_IDLE: if (h2 && !h3) begin
          m_del  <= 1'b1;
          m_cnt  <= 2 + S;
          m_mode <= M_BUSY;
        end
        M_BUSY: if (m_cnt == 1) begin
          m_balls <= m_balls + 1;
          if (int'(binaryWickets) >= MAXW || m_balls + 1 == BPO * OVERS ||
              (m_inn2 && int'(binaryRuns) >= m_target)) begin
            if (!m_inn2) begin
              m_target <= int'(binaryRuns) + 1;
              m_mode   <= M_BRK;
            end else begin
              m_go     <= 1'b1;
              m_winner <= (int'(binaryRuns) >= m_target) ? 2 :
                          ((int'(binaryRuns) + 1 == m_target) ? 3 : 1);
              m_mode   <= M_OVER;
            end
          end else begin
            m_mode <= M_IDLE;
          end
        end else begin
          m_cnt <= m_cnt - 1;
        end
        M_BRK: if (h2 && !h3) begin
          m_ts    <= 1'b1;
          m_inn2  <= 1'b1;
          m_balls <= 0;
          m_mode  <= M_IDLE;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk_fpga) begin
    if (armed) begin
      vectors++;
      if (delivery !== m_del || teamSwitch !== m_ts || gameOver !== m_go ||
          int'(ballInOver) != m_balls % BPO || int'(overCount) != m_balls / BPO ||
          int'(target) != m_target || int'(winner) != m_winner) begin
        miscompares++;
        $display("FAIL cycle_model t=%0t got del=%b ts=%b go=%b bio=%0d oc=%0d tgt=%0d win=%0d want del=%b ts=%b go=%b bio=%0d oc=%0d tgt=%0d win=%0d",
                 $time, delivery, teamSwitch, gameOver, ballInOver, overCount, target, winner,
                 m_del, m_ts, m_go, m_balls % BPO, m_balls / BPO, m_target, m_winner);
      end
      if (delivery === 1'b1) n_del++;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_fpga);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bowl_btn = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic bowl();
    bowl_btn = 1'b1;
    tick(2);
    bowl_btn = 1'b0;
    tick(5 + S);
  endtask

  task automatic inn1_wickets();
    do_reset();
    binaryRuns = 8'd0; binaryWickets = 4'd0;
    repeat (7) bowl();
    binaryRuns = 8'd37; binaryWickets = 4'd10;
    bowl();
    check("wk_target", int'(target), 38);
    check("wk_overs", int'(overCount), 1);
    check("wk_ball", int'(ballInOver), 2);
    check("wk_switch", int'(teamSwitch), 0);
    binaryRuns = 8'd0; binaryWickets = 4'd0;
    bowl();
    check("wk_break_switch", int'(teamSwitch), 1);
  endtask

  int d0;

  initial begin
    @(negedge clk_fpga);
    armed = 1'b1;
    tick(2);
    reset = 1'b0;
    check("rst_delivery", int'(delivery), 0);
    check("rst_target", int'(target), 0);
    check("rst_winner", int'(winner), 0);

    // Handshake plus a rejected press during settling.
    tick(2);
    d0 = n_del;
    bowl_btn = 1'b1; tick(1);
    bowl_btn = 1'b0; tick(1);
    bowl_btn = 1'b1; tick(1);
    bowl_btn = 1'b0; tick(8);
    check("hs_one_delivery", n_del - d0, 1);
    check("hs_ball", int'(ballInOver), 1);

    // Innings 1 ends on overs.
    do_reset();
    binaryRuns = 8'd0; binaryWickets = 4'd0;
    repeat (12) bowl();
    check("ov_overs", int'(overCount), 2);
    check("ov_target", int'(target), 1);
    check("ov_switch", int'(teamSwitch), 0);
    d0 = n_del;
    bowl();
    check("ov_break_nodel", n_del - d0, 0);
    check("ov_break_switch", int'(teamSwitch), 1);

    // Reset while a ball is settling in innings 2.
    bowl_btn = 1'b1; tick(2);
    bowl_btn = 1'b0; tick(2);
    reset = 1'b1; tick(1);
    reset = 1'b0;
    check("mid_rst_switch", int'(teamSwitch), 0);
    check("mid_rst_target", int'(target), 0);
    check("mid_rst_ball", int'(ballInOver), 0);
    tick(6);
    bowl();
    check("post_rst_ball", int'(ballInOver), 1);

    // Chase achieved on the third ball.
    inn1_wickets();
    repeat (2) bowl();
    binaryRuns = 8'd38;
    bowl();
    check("chase_go", int'(gameOver), 1);
    check("chase_win", int'(winner), 2);
    d0 = n_del;
    bowl();
    check("chase_nodel", n_del - d0, 0);

    // Overs exhausted one run short: tie.
    inn1_wickets();
    binaryRuns = 8'd37;
    repeat (12) bowl();
    check("tie_win", int'(winner), 3);
    check("tie_go", int'(gameOver), 1);

    // Overs exhausted well short: team 1 wins.
    inn1_wickets();
    binaryRuns = 8'd20;
    repeat (12) bowl();
    check("t1_win", int'(winner), 1);
    check("t1_overs", int'(overCount), 2);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
